dispatch_ctrl: RTL and testbench
================================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk_in and rst_in.
REQ-002 Ports SHALL be as follows:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low freezes the block.
- flush  in  1  rollback; discard held instruction.
- iq_valid  in  1  instruction queue presents an instruction.
- iq_instr  in  32  instruction word.
- iq_pc  in  32  instruction PC.
- iq_pred_jump  in  1  predictor decision.
- iq_ready  out  1  block accepts the instruction this cycle.
- dec_instr  out  32  held word driven to the decoder.
- dec_is_ls, dec_is_jump  in  1 each  decoder results.
- dec_optype  in  6  decoder optype; 0 means NOP/illegal.
- dec_rd, dec_rs1, dec_rs2  in  5 each  decoder register fields.
- dec_imm  in  32  decoder immediate.
- rob_free  in  1  ROB can take one entry.
- rob_idx  in  4  current ROB tail index.
- rs_full, lsb_full  in  1 each  reservation station / load-store buffer full.
- rob_alloc, rs_issue, lsb_issue  out  1 each  registered one-cycle pulses.
- out_optype  out  6  issued payload.
- out_rd, out_rs1, out_rs2  out  5 each  issued payload.
- out_imm, out_pc  out  32 each  issued payload.
- out_rob_idx  out  4  issued payload.
- out_pred_jump  out  1  issued payload.
- illegal_pulse  out  1  one-cycle pulse on a dropped illegal instruction.
- dispatch_cnt  out  32  count of issued instructions.

Function
REQ-003 The block SHALL have two states: EMPTY (no held instruction) and HOLD (hold register valid).
REQ-004 dec_instr SHALL equal the hold register's word; the decoder's results are consumed in the same cycle.
REQ-005 The target SHALL be lsb_issue if dec_is_ls=1, otherwise rs_issue; jumps and branches go to the RS.
REQ-006 go SHALL equal HOLD & rdy_in & ~flush & dec_optype≠0 & rob_free & ~(target full).
REQ-007 drop SHALL equal HOLD & rdy_in & ~flush & dec_optype=0.
REQ-008 iq_ready SHALL equal rdy_in & ~flush & (EMPTY | go | drop); it is combinational.
REQ-009 On an edge with iq_valid & iq_ready, the block SHALL capture instr, pc and pred_jump into the hold register and enter or stay in HOLD.
- On go or drop without capture, the block SHALL go to EMPTY.
REQ-010 On an edge with go, the block SHALL, registered and visible next cycle:
- pulse the target issue signal and rob_alloc;
- latch dec_* fields, pc, pred_jump and rob_idx into out_*;
- increment dispatch_cnt, wrapping modulo 2^32.
REQ-011 On an edge with drop, the block SHALL pulse illegal_pulse and SHALL assert no issue or alloc.
REQ-012 rob_alloc, rs_issue, lsb_issue and illegal_pulse SHALL be 0 at every edge without go/drop, including edges with rdy_in=0.
REQ-013 out_* SHALL hold their last values when not issuing.
REQ-014 Sustained throughput SHALL be one instruction per cycle: accept N, issue visible N+2, with back-to-back capture on go cycles.
REQ-015 Flush SHALL have the highest priority among non-reset events:
- on a flush edge, the state goes to EMPTY and there is no capture, issue or alloc;
- pulses issued at the prior edge remain visible for their one cycle.
REQ-016 With rdy_in=0, the state, hold register, out_* and dispatch_cnt SHALL be unchanged.
REQ-017 A stall (target full or rob_free=0) SHALL keep HOLD with iq_ready=0 indefinitely, with no pulses.

Reset
REQ-018 At an edge with rst_in=1 (overriding everything), the block SHALL set:
- state EMPTY, hold register cleared;
- all pulses 0, out_* 0, dispatch_cnt 0.
REQ-019 Reset mid-stall SHALL discard the held instruction without issue.

Verification
REQ-020 Single addi: iq_instr=0x00500093 (addi x1,x0,5), rob_idx=3, all free.
- Response: rs_issue=1 and rob_alloc=1 two cycles after acceptance; out_rd=1, out_imm=5, out_rob_idx=3; dispatch_cnt=1.
REQ-021 Load stall: lw 0x0040A103 with lsb_full=1 for 4 cycles.
- Response: iq_ready=0 and no pulses for 4 cycles.
- lsb_full=0 -> lsb_issue=1 next cycle; out_rd=2, out_rs1=1, out_imm=4.
REQ-022 Back-to-back: 8 consecutive addi with iq_valid=1 continuously.
- Response: 8 rs_issue pulses on 8 consecutive cycles; dispatch_cnt=8.
REQ-023 Flush while HOLD (rob_free=0): assert flush for one cycle, then release rob_free.
- Response: no issue, no alloc, state EMPTY; the next instruction dispatches normally.
REQ-024 Illegal word 0x00000000: illegal_pulse=1 one cycle, no rob_alloc, dispatch_cnt unchanged.
REQ-025 rdy_in low for 3 cycles during HOLD; rst_in during a stall.
- Response: rdy_in low -> no state change, iq_ready=0.
- rst_in -> all outputs 0; the held instruction is never issued.

Source files
------------

// File: rtl/dispatch_ctrl_if.sv
// ============================================================================
// Module      : dispatch_ctrl_if
// Description : Instruction-queue, decoder, ROB/RS/LSB and issue-payload
//               signals of the dispatch stage, bundled with modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dispatch_ctrl_if;
    logic        rdy_in;
    logic        flush;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic [31:0] iq_pc;
    logic        iq_pred_jump;
    logic        iq_ready;
    logic [31:0] dec_instr;
    logic        dec_is_ls;
    logic        dec_is_jump;
    logic [5:0]  dec_optype;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic        rob_free;
    logic [3:0]  rob_idx;
    logic        rs_full;
    logic        lsb_full;
    logic        rob_alloc;
    logic        rs_issue;
    logic        lsb_issue;
    logic [5:0]  out_optype;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [3:0]  out_rob_idx;
    logic        out_pred_jump;
    logic        illegal_pulse;
    logic [31:0] dispatch_cnt;

    // Dispatch-controller side.
    modport slave (
        input  rdy_in, flush, iq_valid, iq_instr, iq_pc, iq_pred_jump,
        input  dec_is_ls, dec_is_jump, dec_optype, dec_rd, dec_rs1, dec_rs2, dec_imm,
        input  rob_free, rob_idx, rs_full, lsb_full,
        output iq_ready, dec_instr, rob_alloc, rs_issue, lsb_issue,
        output out_optype, out_rd, out_rs1, out_rs2, out_imm, out_pc,
        output out_rob_idx, out_pred_jump, illegal_pulse, dispatch_cnt
    );

    // Environment side: queue, decoder, ROB and issue consumers.
    modport master (
        output rdy_in, flush, iq_valid, iq_instr, iq_pc, iq_pred_jump,
        output dec_is_ls, dec_is_jump, dec_optype, dec_rd, dec_rs1, dec_rs2, dec_imm,
        output rob_free, rob_idx, rs_full, lsb_full,
        input  iq_ready, dec_instr, rob_alloc, rs_issue, lsb_issue,
        input  out_optype, out_rd, out_rs1, out_rs2, out_imm, out_pc,
        input  out_rob_idx, out_pred_jump, illegal_pulse, dispatch_cnt
    );
endinterface

`default_nettype wire

// File: rtl/dispatch_ctrl.sv
// ============================================================================
// Module      : dispatch_ctrl
// Description : Single-entry dispatch stage: holds one instruction, lets the
//               decoder inspect it and issues it to the RS or LSB with a ROB slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_ctrl (
    input  logic            clk_in,
    input  logic            rst_in,
    dispatch_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_hold_pj;

    logic        r_rob_alloc;
    logic        r_rs_issue;
    logic        r_lsb_issue;
    logic        r_illegal;
    logic [5:0]  r_out_optype;
    logic [4:0]  r_out_rd;
    logic [4:0]  r_out_rs1;
    logic [4:0]  r_out_rs2;
    logic [31:0] r_out_imm;
    logic [31:0] r_out_pc;
    logic [3:0]  r_out_rob_idx;
    logic        r_out_pj;
    logic [31:0] r_dispatch_cnt;

    logic        w_hold;
    logic        w_to_lsb;
    logic        w_target_full;
    logic        w_live;
    logic        w_go;
    logic        w_drop;
    logic        w_ready;
    logic        w_capture;

    // Control-flow instructions always go to the RS, even if a decoder
    // ever flags one as a memory access as well.
    assign w_to_lsb      = bus.dec_is_ls & ~bus.dec_is_jump;
    assign w_target_full = w_to_lsb ? bus.lsb_full : bus.rs_full;

    assign w_hold    = (r_state == ST_HOLD);
    assign w_live    = bus.rdy_in & ~bus.flush;
    assign w_go      = w_hold & w_live & (bus.dec_optype != 6'd0)
                     & bus.rob_free & ~w_target_full;
    assign w_drop    = w_hold & w_live & (bus.dec_optype == 6'd0);
    assign w_ready   = w_live & (~w_hold | w_go | w_drop);
    assign w_capture = bus.iq_valid & w_ready;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.rdy_in) begin
            if (bus.flush) begin
                w_state_nxt = ST_EMPTY;
            end else if (w_capture) begin
                w_state_nxt = ST_HOLD;
            end else if (w_go || w_drop) begin
                w_state_nxt = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hold_instr   <= 32'd0;
            r_hold_pc      <= 32'd0;
            r_hold_pj      <= 1'b0;
            r_rob_alloc    <= 1'b0;
            r_rs_issue     <= 1'b0;
            r_lsb_issue    <= 1'b0;
            r_illegal      <= 1'b0;
            r_out_optype   <= 6'd0;
            r_out_rd       <= 5'd0;
            r_out_rs1      <= 5'd0;
            r_out_rs2      <= 5'd0;
            r_out_imm      <= 32'd0;
            r_out_pc       <= 32'd0;
            r_out_rob_idx  <= 4'd0;
            r_out_pj       <= 1'b0;
            r_dispatch_cnt <= 32'd0;
        end else begin
            // go/drop already exclude rdy_in=0 and flush, so pulses fall to 0 there.
            r_rob_alloc <= w_go;
            r_rs_issue  <= w_go & ~w_to_lsb;
            r_lsb_issue <= w_go & w_to_lsb;
            r_illegal   <= w_drop;

            if (w_capture) begin
                r_hold_instr <= bus.iq_instr;
                r_hold_pc    <= bus.iq_pc;
                r_hold_pj    <= bus.iq_pred_jump;
            end

            if (w_go) begin
                r_out_optype   <= bus.dec_optype;
                r_out_rd       <= bus.dec_rd;
                r_out_rs1      <= bus.dec_rs1;
                r_out_rs2      <= bus.dec_rs2;
                r_out_imm      <= bus.dec_imm;
                r_out_pc       <= r_hold_pc;
                r_out_rob_idx  <= bus.rob_idx;
                r_out_pj       <= r_hold_pj;
                r_dispatch_cnt <= r_dispatch_cnt + 32'd1;
            end
        end
    end

    assign bus.iq_ready      = w_ready;
    assign bus.dec_instr     = r_hold_instr;
    assign bus.rob_alloc     = r_rob_alloc;
    assign bus.rs_issue      = r_rs_issue;
    assign bus.lsb_issue     = r_lsb_issue;
    assign bus.illegal_pulse = r_illegal;
    assign bus.out_optype    = r_out_optype;
    assign bus.out_rd        = r_out_rd;
    assign bus.out_rs1       = r_out_rs1;
    assign bus.out_rs2       = r_out_rs2;
    assign bus.out_imm       = r_out_imm;
    assign bus.out_pc        = r_out_pc;
    assign bus.out_rob_idx   = r_out_rob_idx;
    assign bus.out_pred_jump = r_out_pj;
    assign bus.dispatch_cnt  = r_dispatch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
// ============================================================================
// Module      : tb_dispatch_ctrl
// Description : Scoreboard bench for dispatch_ctrl with a small RV32 decoder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dispatch_ctrl;

    typedef struct {
        bit          ill;
        bit          ls;
        logic [5:0]  opt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic        pj;
        logic [31:0] cnt;
        bit          consec;
        bit          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   last_cyc = 0;
    logic [31:0] exp_cnt = 32'd0;
    exp_t q[$];
    exp_t m_e;

    dispatch_ctrl_if bus ();

    dispatch_ctrl dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decoder model: opcode classes of the handful of formats used here.
    wire [6:0] w_op = bus.dec_instr[6:0];
    assign bus.dec_is_ls   = (w_op == 7'h03) || (w_op == 7'h23);
    assign bus.dec_is_jump = (w_op == 7'h6f) || (w_op == 7'h67) || (w_op == 7'h63);
    assign bus.dec_optype  = (w_op == 7'h13) ? 6'd1 : (w_op == 7'h03) ? 6'd2 :
                             (w_op == 7'h23) ? 6'd3 : (w_op == 7'h63) ? 6'd4 :
                             (w_op == 7'h6f) ? 6'd5 : 6'd0;
    assign bus.dec_rd  = bus.dec_instr[11:7];
    assign bus.dec_rs1 = bus.dec_instr[19:15];
    assign bus.dec_rs2 = bus.dec_instr[24:20];
    assign bus.dec_imm = (w_op == 7'h23) ?
        {{20{bus.dec_instr[31]}}, bus.dec_instr[31:25], bus.dec_instr[11:7]} :
        {{20{bus.dec_instr[31]}}, bus.dec_instr[31:20]};

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(input bit ill, input bit ls, input logic [5:0] opt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input bit consec, input bit lat);
        exp_t e;
        e = '{ill: ill, ls: ls, opt: opt, rd: rd, rs1: rs1, rs2: rs2, imm: imm,
              pc: 32'd0, rob: 4'd0, pj: 1'b0, cnt: 32'd0, consec: consec, lat: lat, acc: 0};
        return e;
    endfunction

    // Monitor: every issue/illegal pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (bus.rs_issue || bus.lsb_issue || bus.illegal_pulse) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual rs=%0b lsb=%0b ill=%0b required none",
                         bus.rs_issue, bus.lsb_issue, bus.illegal_pulse);
            end else begin
                m_e = q.pop_front();
                if (m_e.ill) begin
                    chk("ill_pulse", 64'(bus.illegal_pulse), 64'd1);
                    chk("ill_no_issue", 64'({bus.rob_alloc, bus.rs_issue, bus.lsb_issue}), 64'd0);
                    chk("ill_cnt", 64'(bus.dispatch_cnt), 64'(m_e.cnt));
                end else begin
                    chk("issue_rs", 64'(bus.rs_issue), 64'(!m_e.ls));
                    chk("issue_lsb", 64'(bus.lsb_issue), 64'(m_e.ls));
                    chk("rob_alloc", 64'({bus.rob_alloc, bus.illegal_pulse}), 64'b10);
                    chk("out_optype", 64'(bus.out_optype), 64'(m_e.opt));
                    chk("out_regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}),
                        64'({m_e.rd, m_e.rs1, m_e.rs2}));
                    chk("out_imm", 64'(bus.out_imm), 64'(m_e.imm));
                    chk("out_pc", 64'(bus.out_pc), 64'(m_e.pc));
                    chk("out_rob_pj", 64'({bus.out_rob_idx, bus.out_pred_jump}), 64'({m_e.rob, m_e.pj}));
                    chk("dispatch_cnt", 64'(bus.dispatch_cnt), 64'(m_e.cnt));
                end
                if (m_e.lat)    chk("latency", 64'(cyc - m_e.acc), 64'd1);
                if (m_e.consec) chk("consecutive", 64'(cyc - last_cyc), 64'd1);
                last_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic pj,
                        input bit want, input exp_t e_in);
        exp_t e;
        int t;
        e = e_in;
        t = 0;
        @(negedge clk);
        bus.iq_valid = 1'b1;
        bus.iq_instr = instr;
        bus.iq_pc = pc;
        bus.iq_pred_jump = pj;
        #1;
        while (!bus.iq_ready && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.iq_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual iq_ready=0 required 1 instr=%08h", instr);
            bus.iq_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (want) begin
                e.pc  = pc;
                e.pj  = pj;
                e.rob = bus.rob_idx;
                if (!e.ill) exp_cnt = exp_cnt + 32'd1;
                e.cnt = exp_cnt;
                e.acc = cyc;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.iq_valid = 1'b0;
    endtask

    task automatic quiet(input int n, input bit stalled);
        repeat (n) begin
            @(negedge clk);
            #1;
            chk("quiet_pulses", 64'({bus.rob_alloc, bus.rs_issue, bus.lsb_issue, bus.illegal_pulse}), 64'd0);
            if (stalled) chk("stall_iq_ready", 64'(bus.iq_ready), 64'd0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk("drain_queue", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] instr;
        rst = 1'b1;
        bus.rdy_in = 1'b1;  bus.flush = 1'b0;     bus.iq_valid = 1'b0;
        bus.iq_instr = '0;  bus.iq_pc = '0;       bus.iq_pred_jump = 1'b0;
        bus.rob_free = 1'b1; bus.rob_idx = 4'd0;  bus.rs_full = 1'b0;
        bus.lsb_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_iq_ready", 64'(bus.iq_ready), 64'd1);
        chk("rst_pulses", 64'({bus.rob_alloc, bus.rs_issue, bus.lsb_issue, bus.illegal_pulse}), 64'd0);
        chk("rst_cnt", 64'(bus.dispatch_cnt), 64'd0);
        chk("rst_out", 64'({bus.out_rd, bus.out_imm, bus.out_rob_idx}), 64'd0);

        // Single addi x1,x0,5
        bus.rob_idx = 4'd3;
        send(32'h00500093, 32'h0000_1000, 1'b0, 1'b1, mk(0, 0, 6'd1, 5'd1, 5'd0, 5'd5, 32'd5, 0, 1));
        idle();
        drain();
        chk("addi_cnt", 64'(bus.dispatch_cnt), 64'd1);

        // lw x2,4(x1) against a full LSB
        bus.lsb_full = 1'b1;
        bus.rob_idx = 4'd4;
        send(32'h0040A103, 32'h0000_1004, 1'b1, 1'b1, mk(0, 1, 6'd2, 5'd2, 5'd1, 5'd4, 32'd4, 0, 0));
        idle();
        quiet(4, 1);
        bus.lsb_full = 1'b0;
        drain();

        // Eight back-to-back addi xk,x0,k
        bus.rob_idx = 4'd5;
        for (int k = 1; k <= 8; k++) begin
            instr = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
            send(instr, 32'h2000 + 32'(4 * k), 1'(k & 1), 1'b1,
                 mk(0, 0, 6'd1, 5'(k), 5'd0, 5'(k), 32'(k), k > 1, 1));
        end
        idle();
        drain();
        chk("b2b_cnt", 64'(bus.dispatch_cnt), 64'd10);

        // Flush a stalled addi x3,x0,7
        bus.rob_free = 1'b0;
        send(32'h00700193, 32'h0000_3000, 1'b0, 1'b0, mk(0, 0, 6'd1, 5'd3, 5'd0, 5'd7, 32'd7, 0, 0));
        idle();
        bus.flush = 1'b1;
        #1;
        chk("flush_iq_ready", 64'(bus.iq_ready), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.rob_free = 1'b1;
        quiet(3, 0);
        chk("flush_empty_ready", 64'(bus.iq_ready), 64'd1);
        send(32'h00900213, 32'h0000_3004, 1'b1, 1'b1, mk(0, 0, 6'd1, 5'd4, 5'd0, 5'd9, 32'd9, 0, 1));
        idle();
        drain();
        chk("flush_cnt", 64'(bus.dispatch_cnt), 64'd11);

        // Illegal all-zero word
        bus.rob_idx = 4'd6;
        send(32'h00000000, 32'h0000_3008, 1'b0, 1'b1, mk(1, 0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1));
        idle();
        drain();
        chk("ill_cnt_after", 64'(bus.dispatch_cnt), 64'd11);

        // rdy_in low for three edges while holding addi x5,x0,1
        bus.rob_free = 1'b0;
        bus.rob_idx = 4'd7;
        send(32'h00100293, 32'h0000_4000, 1'b0, 1'b1, mk(0, 0, 6'd1, 5'd5, 5'd0, 5'd1, 32'd1, 0, 0));
        idle();
        bus.rdy_in = 1'b0;
        bus.rob_free = 1'b1;
        repeat (3) begin
            #1;
            chk("rdy_iq_ready", 64'(bus.iq_ready), 64'd0);
            chk("rdy_hold_word", 64'(bus.dec_instr), 64'h00100293);
            chk("rdy_cnt", 64'(bus.dispatch_cnt), 64'd11);
            @(negedge clk);
        end
        #1;
        chk("rdy_pulses", 64'({bus.rob_alloc, bus.rs_issue, bus.lsb_issue, bus.illegal_pulse}), 64'd0);
        bus.rdy_in = 1'b1;
        drain();

        // Reset during an RS-full stall of addi x6,x0,2
        bus.rs_full = 1'b1;
        send(32'h00200313, 32'h0000_5000, 1'b0, 1'b0, mk(0, 0, 6'd1, 5'd6, 5'd0, 5'd2, 32'd2, 0, 0));
        idle();
        quiet(2, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rs_full = 1'b0;
        exp_cnt = 32'd0;
        #1;
        chk("mrst_pulses", 64'({bus.rob_alloc, bus.rs_issue, bus.lsb_issue, bus.illegal_pulse}), 64'd0);
        chk("mrst_out", 64'({bus.out_optype, bus.out_rd, bus.out_rs1, bus.out_rob_idx, bus.out_pred_jump}), 64'd0);
        chk("mrst_out_imm_pc", 64'({bus.out_imm, bus.out_pc}), 64'd0);
        chk("mrst_cnt_hold", 64'({bus.dispatch_cnt, bus.dec_instr}), 64'd0);
        chk("mrst_iq_ready", 64'(bus.iq_ready), 64'd1);
        quiet(3, 0);

        bus.rob_idx = 4'd2;
        send(32'h00500093, 32'h0000_6000, 1'b1, 1'b1, mk(0, 0, 6'd1, 5'd1, 5'd0, 5'd5, 32'd5, 0, 1));
        idle();
        drain();
        chk("final_cnt", 64'(bus.dispatch_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
